// File: rtl/data_sram_responder.sv
// data_sram_responder: data-SRAM slave model with word memory and in-order fixed-latency response queue
module data_sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int QUEUE_DEPTH = 4,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    input  logic        resp_hold,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic                  r_q_wr [QUEUE_DEPTH];
    logic [31:0]           r_q_data [QUEUE_DEPTH];
    logic [LW-1:0]         r_q_cnt [QUEUE_DEPTH];
    logic [QW-1:0]         r_wptr;
    logic [QW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_data_ok;
    logic [31:0]           r_rdata;
    logic                  w_acc;
    logic                  w_ret;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_unused;

    assign w_idx             = data_sram_addr[DEPTH_LOG2+1:2];
    assign data_sram_addr_ok = data_sram_req && (r_count != CW'(QUEUE_DEPTH));
    assign w_acc             = data_sram_addr_ok;
    assign w_ret             = (r_count != '0) && (r_q_cnt[r_rptr] == '0) && !resp_hold;
    assign w_unused          = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};
    assign data_sram_data_ok = r_data_ok;
    assign data_sram_rdata   = r_rdata;

    // Byte-enabled write into the array at the accept edge; the array is never cleared
    always_ff @(posedge clk) begin
        if (w_acc && data_sram_wr)
            for (int k = 0; k < 4; k++)
                if (data_sram_wstrb[k]) r_mem[w_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
    end

    // Load the tail entry with the pre-write array word, and count every entry's latency down to zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (w_acc && r_wptr == QW'(i)) begin
                r_q_wr[i]   <= data_sram_wr;
                r_q_data[i] <= r_mem[w_idx];
                r_q_cnt[i]  <= LW'(LATENCY - 1);
            end else if (r_q_cnt[i] != '0) begin
                r_q_cnt[i]  <= r_q_cnt[i] - 1'b1;
            end
        end
    end

    // Queue occupancy, pointers and the registered response port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_count   <= r_count + CW'(w_acc) - CW'(w_ret);
            if (w_acc) r_wptr <= r_wptr + 1'b1;
            if (w_ret) r_rptr <= r_rptr + 1'b1;
            r_data_ok <= w_ret;
            if (w_ret) r_rdata <= r_q_wr[r_rptr] ? 32'h0 : r_q_data[r_rptr];
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized and directed checks of data_sram_responder against a queue-based reference model
module tb_data_sram_responder;
    localparam int QD  = 4;
    localparam int LAT = 2;

    logic        clk = 0;
    logic        reset = 1;
    logic        req = 0;
    logic        wr = 0;
    logic        hold = 0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        bit          w;
        logic [31:0] d;
        longint      rdy;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mem_m[int];
    logic        exp_dok = 0;
    logic [31:0] exp_rdata = 0;
    longint      cyc = 0;
    longint      n_acc = 0;
    logic [31:0] got[$];
    int          dc[$];

    data_sram_responder #(.DEPTH_LOG2(10), .QUEUE_DEPTH(QD), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .data_sram_req(req),
        .data_sram_wr(wr),
        .data_sram_size(size),
        .data_sram_addr(addr),
        .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata),
        .resp_hold(hold),
        .data_sram_addr_ok(addr_ok),
        .data_sram_data_ok(data_ok),
        .data_sram_rdata(rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model: a list of pending responses, each ready LAT edges after its accept edge
    always @(posedge clk or posedge reset) begin : model
        bit          acc;
        int          idx;
        ent_t        e;
        logic [31:0] word;
        if (reset) begin
            mq.delete();
            exp_dok = 0;
            exp_rdata = 0;
        end else begin
            acc = req && (mq.size() != QD);
            exp_dok = 0;
            if (mq.size() > 0 && cyc >= mq[0].rdy && !hold) begin
                exp_dok = 1;
                exp_rdata = mq[0].w ? 32'h0 : mq[0].d;
                void'(mq.pop_front());
            end
            if (acc) begin
                n_acc++;
                idx = int'((addr >> 2) % 1024);
                word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                e.w = wr;
                e.d = word;
                e.rdy = cyc + LAT;
                mq.push_back(e);
                if (wr) begin
                    for (int k = 0; k < 4; k++)
                        if (wstrb[k]) word[8*k +: 8] = wdata[8*k +: 8];
                    mem_m[idx] = word;
                end
            end
            cyc++;
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic h);
        req = r;
        wr = w;
        addr = a;
        wstrb = s;
        wdata = d;
        hold = h;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (data_ok !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %b/%h exp 0/00000000", data_ok, rdata);
        end
        n_tests++;
        if (addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_aok_idle: got %b exp 0", addr_ok);
        end
        req = 1;
        #1;
        n_tests++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_aok_req: got %b exp 1", addr_ok);
        end
        req = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
        #1;
        n_tests++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_aok_wr: got %b exp 1", addr_ok);
        end
        @(negedge clk);
        drive(1, 0, 32'h10, 4'h0, 32'h0, 0);
        #1;
        n_tests++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_aok_rd: got %b exp 1", addr_ok);
        end
        @(negedge clk);
        n_tests++;
        if (data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: got %b exp 0", data_ok);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (data_ok !== 1'b1 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_wr_resp: got %b/%h exp 1/00000000", data_ok, rdata);
        end
        @(negedge clk);
        n_tests++;
        if (data_ok !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rd_resp: got %b/%h exp 1/deadbeef", data_ok, rdata);
        end
        @(negedge clk);
        n_tests++;
        if (data_ok !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_hold_rdata: got %b/%h exp 0/deadbeef", data_ok, rdata);
        end
    endtask

    task automatic test_byte();
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive(1, 1, 32'h11, 4'b0010, 32'h0000AA00, 0);
            else if (c == 1) drive(1, 0, 32'h10, 4'h0, 32'h0, 0);
            else drive(0, 0, 0, 0, 0, 0);
            #1;
            n_tests++;
            if (addr_ok !== (req && mq.size() != QD)) begin
                n_fail++;
                $display("FAIL byte_aok c=%0d: got %b exp %b", c, addr_ok, req);
            end
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL byte_resp c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
            if (data_ok) got.push_back(rdata);
        end
        n_tests++;
        if (got.size() != 2 || got[1] !== 32'hDEADAAEF) begin
            n_fail++;
            $display("FAIL byte_merge: got %0d resp last %h exp 2 resp deadaaef", got.size(),
                     got.size() > 0 ? got[got.size()-1] : 32'h0);
        end
    endtask

    task automatic test_hold_full();
        int i;
        logic exp_a;
        for (int c = 0; c < 10; c++) begin
            drive(c < 6, 1, 32'h40 + 32'(4 * c), 4'hF, 32'hA5000000 | 32'(c), 0);
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL hold_prep c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
        end
        got.delete();
        dc.delete();
        i = 0;
        for (int c = 0; c < 20; c++) begin
            drive(i < 6, 0, 32'h40 + 32'(4 * i), 4'h0, 32'h0, c < 8);
            #1;
            n_tests++;
            if (addr_ok !== (req && mq.size() != QD)) begin
                n_fail++;
                $display("FAIL hold_aok_model c=%0d: got %b exp %b", c, addr_ok, !addr_ok);
            end
            if (c <= 9) begin
                exp_a = (c < 4) || (c == 9);
                n_tests++;
                if (addr_ok !== exp_a) begin
                    n_fail++;
                    $display("FAIL hold_aok_pattern c=%0d: got %b exp %b", c, addr_ok, exp_a);
                end
            end
            if (addr_ok) i++;
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL hold_resp c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
            if (data_ok) begin
                got.push_back(rdata);
                dc.push_back(c);
            end
        end
        n_tests++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL hold_count: got %0d exp 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (got[k] !== (32'hA5000000 | 32'(k))) begin
                    n_fail++;
                    $display("FAIL hold_order k=%0d: got %h exp %h", k, got[k], 32'hA5000000 | 32'(k));
                end
            end
        end
        n_tests++;
        if (dc.size() < 4 || dc[0] != 8 || dc[3] != 11) begin
            n_fail++;
            $display("FAIL hold_burst: got first %0d fourth %0d exp 8 11",
                     dc.size() > 0 ? dc[0] : -1, dc.size() > 3 ? dc[3] : -1);
        end
    endtask

    task automatic test_raw();
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1, 1, 32'h20, 4'hF, 32'h1, 0);
            else if (c == 1) drive(1, 0, 32'h20, 4'h0, 32'h0, 0);
            else if (c == 2) drive(1, 0, 32'h20 + (32'h1 << 12), 4'h0, 32'h0, 0);
            else drive(0, 0, 0, 0, 0, 0);
            #1;
            n_tests++;
            if (addr_ok !== (req && mq.size() != QD)) begin
                n_fail++;
                $display("FAIL raw_aok c=%0d: got %b exp %b", c, addr_ok, req);
            end
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL raw_resp c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
            if (data_ok) got.push_back(rdata);
        end
        n_tests++;
        if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h1 || got[2] !== 32'h1) begin
            n_fail++;
            $display("FAIL raw_values: got %0d resp last %h exp 3 resp 0,1,1", got.size(),
                     got.size() > 0 ? got[got.size()-1] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1, 1, 32'h30, 4'hF, 32'h12345678, 1);
            else drive(1, 0, 32'h10 + 32'(16 * c), 4'h0, 32'h0, 1);
            #1;
            n_tests++;
            if (addr_ok !== (c < 4)) begin
                n_fail++;
                $display("FAIL rmid_aok c=%0d: got %b exp %b", c, addr_ok, c < 4);
            end
            @(negedge clk);
        end
        #2;
        reset = 1;
        #1;
        n_tests++;
        if (data_ok !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_clear: got %b/%h exp 0/00000000", data_ok, rdata);
        end
        n_tests++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_count: got addr_ok %b exp 1", addr_ok);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (data_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_stale c=%0d: got %b exp 0", c, data_ok);
            end
        end
        got.delete();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1, 0, 32'h30, 4'h0, 32'h0, 0);
            else drive(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rmid_resp c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
            if (data_ok) got.push_back(rdata);
        end
        n_tests++;
        if (got.size() != 1 || got[0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rmid_mem: got %0d resp %h exp 1 resp 12345678", got.size(),
                     got.size() > 0 ? got[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        longint acc0;
        int ndok;
        logic [31:0] a;
        for (int c = 0; c < 16; c++) begin
            drive(1, 1, 32'h40 + 32'(4 * c), 4'hF, $urandom(), 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        acc0 = n_acc;
        ndok = 0;
        for (int c = 0; c < 320; c++) begin
            a = ($urandom() & 32'hFFFFF000) | (32'(16 + $urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if (c < 300)
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a, 4'($urandom_range(0, 15)),
                      $urandom(), $urandom_range(0, 3) == 0);
            else
                drive(0, 0, 0, 0, 0, 0);
            #1;
            n_tests++;
            if (addr_ok !== (req && mq.size() != QD)) begin
                n_fail++;
                $display("FAIL rand_aok c=%0d: got %b exp %b", c, addr_ok, !addr_ok);
            end
            @(negedge clk);
            n_tests++;
            if (data_ok !== exp_dok || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rand_resp c=%0d: got %b/%h exp %b/%h", c, data_ok, rdata, exp_dok, exp_rdata);
            end
            if (data_ok) ndok++;
        end
        n_tests++;
        if (longint'(ndok) != n_acc - acc0) begin
            n_fail++;
            $display("FAIL rand_total: got %0d data_ok exp %0d", ndok, n_acc - acc0);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        test_byte();
        test_hold_full();
        test_raw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
